sr_latch_checker: RTL and testbench

Clocked monitor that sits on the four wires of a NOR-style SR latch (S, R, Q, notQ) and checks the latch's responses against a reference model. It also flags forbidden input combinations and counts errors. It is the checking end of the latch stimulus path: a driver sequences S/R, and this block judges Q/notQ after a settle window. It can be instantiated next to any latch in simulation or in a self-checking top.

---
 rtl/sr_chk_pkg.sv | 15 +
 rtl/sr_sync2.sv | 29 ++
 rtl/sr_latch_checker.sv | 125 ++++++++++++
 tb/tb_sr_latch_checker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sr_chk_pkg.sv
// Shared types and {s,r} encodings for the SR latch checker.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_KNOWN   = 2'd1,
    ST_FORBID  = 2'd2
  } st_t;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

endpackage

// File: rtl/sr_sync2.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
module sr_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Clocked monitor that checks a NOR SR latch's Q/notQ against a reference model.
// Define SR_CHK_SYNC_EN to pass all four observed wires through two-flop synchronizers.
module sr_latch_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_n,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             forbidden,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);
  import sr_chk_pkg::*;

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic s_i, r_i, q_i, q_n_i;

`ifdef SR_CHK_SYNC_EN
  sr_sync2 u_sync_s   (.clk(clk), .rst(rst), .d(s),   .q(s_i));
  sr_sync2 u_sync_r   (.clk(clk), .rst(rst), .d(r),   .q(r_i));
  sr_sync2 u_sync_q   (.clk(clk), .rst(rst), .d(q),   .q(q_i));
  sr_sync2 u_sync_q_n (.clk(clk), .rst(rst), .d(q_n), .q(q_n_i));
`else
  assign s_i   = s;
  assign r_i   = r;
  assign q_i   = q;
  assign q_n_i = q_n;
`endif

  st_t              state_q, state_d;
  logic             exp_q_q, exp_q_d;
  logic [1:0]       prev_sr_q, prev_sr_d;
  logic [3:0]       settle_q, settle_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;

  logic [1:0] sr;
  logic       change;
  logic       chk_en;
  logic       mismatch;

  always_comb begin
    sr        = {s_i, r_i};
    change    = (sr != prev_sr_q);
    prev_sr_d = sr;
    chk_en    = (settle_q == 4'd0) && !change;

    // An input change always restarts the settle window, even on the cycle it would expire.
    if (change) begin
      settle_d = SETTLE_INIT;
    end else if (settle_q != 4'd0) begin
      settle_d = settle_q - 4'd1;
    end else begin
      settle_d = settle_q;
    end

    state_d = state_q;
    exp_q_d = exp_q_q;
    case (sr)
      SR_SET: begin
        state_d = ST_KNOWN;
        exp_q_d = 1'b1;
      end
      SR_RST: begin
        state_d = ST_KNOWN;
        exp_q_d = 1'b0;
      end
      SR_BAD: state_d = ST_FORBID;
      default: begin
        // Releasing 11 to 00 is a race in a real latch, so the outcome is unknown.
        if (state_q != ST_KNOWN) state_d = ST_UNKNOWN;
      end
    endcase

    // Checks use the model state built from earlier samples of the same {s,r}.
    case (state_q)
      ST_KNOWN:  mismatch = (q_i != exp_q_q) || (q_n_i != ~exp_q_q);
      ST_FORBID: mismatch = q_i || q_n_i;
      default:   mismatch = (q_i == q_n_i);
    endcase

    err_d     = chk_en && mismatch;
    chk_cnt_d = (chk_en && (chk_cnt_q != CNT_MAX)) ? chk_cnt_q + CNT_ONE : chk_cnt_q;
    err_cnt_d = (err_d && (err_cnt_q != CNT_MAX)) ? err_cnt_q + CNT_ONE : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_UNKNOWN;
      exp_q_q   <= 1'b0;
      prev_sr_q <= SR_HOLD;
      settle_q  <= 4'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q_q   <= exp_q_d;
      prev_sr_q <= prev_sr_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign exp_q     = exp_q_q;
  assign exp_valid = (state_q == ST_KNOWN);
  assign forbidden = (state_q == ST_FORBID);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign chk_cnt   = chk_cnt_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Directed bench for sr_latch_checker; a CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_sr_latch_checker;

  logic clk = 1'b0;
  logic rst, s, r, q, q_n;

  logic       exp_q, exp_valid, forbidden, err;
  logic [7:0] err_cnt, chk_cnt;
  logic       sm_exp_q, sm_exp_valid, sm_forbidden, sm_err;
  logic [1:0] sm_err_cnt, sm_chk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .q_n(q_n),
    .exp_q(exp_q), .exp_valid(exp_valid), .forbidden(forbidden), .err(err),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt)
  );

  sr_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .q_n(q_n),
    .exp_q(sm_exp_q), .exp_valid(sm_exp_valid), .forbidden(sm_forbidden), .err(sm_err),
    .err_cnt(sm_err_cnt), .chk_cnt(sm_chk_cnt)
  );

  task automatic applyStimulus(input logic s_v, input logic r_v, input logic q_v, input logic qn_v);
    s   = s_v;
    r   = r_v;
    q   = q_v;
    q_n = qn_v;
  endtask

  task automatic stepClock(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, required %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stepClock(3);
    checkOutput("rst_exp_valid", {7'd0, exp_valid}, 8'd0);
    checkOutput("rst_forbidden", {7'd0, forbidden}, 8'd0);
    checkOutput("rst_err",       {7'd0, err},       8'd0);
    checkOutput("rst_exp_q",     {7'd0, exp_q},     8'd0);
    checkOutput("rst_err_cnt",   err_cnt,           8'd0);
    checkOutput("rst_chk_cnt",   chk_cnt,           8'd0);

    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      stepClock(1);
      checkOutput("unk_chk_cnt", chk_cnt, 8'(i));
      checkOutput("unk_err",     {7'd0, err}, 8'd0);
    end
    checkOutput("unk_exp_valid", {7'd0, exp_valid}, 8'd0);

    // Set: latch responds the cycle after s rises.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    stepClock(1);
    checkOutput("set_exp_q",     {7'd0, exp_q},     8'd1);
    checkOutput("set_exp_valid", {7'd0, exp_valid}, 8'd1);
    checkOutput("set_no_chk",    chk_cnt,           8'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    stepClock(2);
    checkOutput("set_settle_chk", chk_cnt, 8'd3);
    stepClock(1);
    checkOutput("set_first_chk", chk_cnt, 8'd4);
    checkOutput("set_err_cnt",   err_cnt, 8'd0);

    // Reset the latch.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("rst_exp_q0", {7'd0, exp_q}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepClock(3);
    checkOutput("rst_chk_cnt5", chk_cnt, 8'd5);
    checkOutput("rst_err_cnt0", err_cnt, 8'd0);

    // Wrong output for one checked cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    stepClock(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    stepClock(2);
    checkOutput("wrong_pre_err", {7'd0, err}, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("wrong_err",     {7'd0, err}, 8'd1);
    checkOutput("wrong_err_cnt", err_cnt,     8'd1);
    checkOutput("wrong_chk_cnt", chk_cnt,     8'd6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("wrong_err_drop", {7'd0, err}, 8'd0);
    checkOutput("wrong_cnt_hold", err_cnt,     8'd1);

    // Forbidden input, then release into the unknown state.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("forb_level",     {7'd0, forbidden}, 8'd1);
    checkOutput("forb_exp_valid", {7'd0, exp_valid}, 8'd0);
    stepClock(3);
    checkOutput("forb_chk_cnt", chk_cnt,     8'd8);
    checkOutput("forb_err",     {7'd0, err}, 8'd0);
    checkOutput("forb_err_cnt", err_cnt,     8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepClock(1);
    checkOutput("rel_forbidden", {7'd0, forbidden}, 8'd0);
    checkOutput("rel_exp_valid", {7'd0, exp_valid}, 8'd0);
    stepClock(3);
    checkOutput("rel_chk_cnt", chk_cnt, 8'd9);
    checkOutput("rel_err_cnt", err_cnt, 8'd1);

    // Toggle s every cycle with q/q_n both high: nothing may be checked.
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 1'b1, 1'b1);
      stepClock(1);
      checkOutput("mask_err", {7'd0, err}, 8'd0);
    end
    checkOutput("mask_chk_cnt", chk_cnt, 8'd9);
    checkOutput("mask_err_cnt", err_cnt, 8'd1);
    checkOutput("mask_exp_q",   {7'd0, exp_q}, 8'd1);

    // Five consecutive checked mismatches in the known state (exp_q=1).
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepClock(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      stepClock(1);
      checkOutput("sat_err",       {7'd0, err},          8'd1);
      checkOutput("sat_err_cnt",   err_cnt,              8'(1 + i));
      checkOutput("sat_small_cnt", {6'd0, sm_err_cnt},   (i >= 2) ? 8'd3 : 8'd2);
    end
    checkOutput("sat_small_chk", {6'd0, sm_chk_cnt}, 8'd3);

    // Mid-run reset clears all counts.
    rst = 1'b1;
    stepClock(1);
    checkOutput("mid_rst_small_cnt", {6'd0, sm_err_cnt}, 8'd0);
    checkOutput("mid_rst_err_cnt",   err_cnt,            8'd0);
    checkOutput("mid_rst_chk_cnt",   chk_cnt,            8'd0);
    checkOutput("mid_rst_err",       {7'd0, err},        8'd0);
    checkOutput("mid_rst_exp_valid", {7'd0, exp_valid},  8'd0);
    rst = 1'b0;
    stepClock(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
